// File: rtl/io_port_bank.sv
// Bank of NPORTS registered output ports with load/set/clear/toggle writes, and NPORTS
// synchronised input ports with sticky change flags and a masked interrupt.
module io_port_bank #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NPORTS = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [1:0]               wr_op,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [SEL_W-1:0]         rd_sel,
  input  logic                     rd_ack,
  input  logic [NPORTS-1:0]        irq_mask,
  input  logic [NPORTS*WIDTH-1:0]  in_ports,
  output logic [NPORTS*WIDTH-1:0]  out_ports,
  output logic [WIDTH-1:0]         rd_data,
  output logic [NPORTS-1:0]        out_stb,
  output logic [NPORTS-1:0]        evt,
  output logic                     irq
);

  typedef enum logic [1:0] {
    OpLoad = 2'b00,
    OpSet  = 2'b01,
    OpClr  = 2'b10,
    OpTgl  = 2'b11
  } op_e;

  // Packed so that element p lands on bits [p*WIDTH +: WIDTH] of the flat buses.
  logic [NPORTS-1:0][WIDTH-1:0] out_q, out_d;
  logic [NPORTS-1:0][WIDTH-1:0] in_vec;
  logic [NPORTS-1:0][WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [NPORTS-1:0]            stb_q, stb_d;
  logic [NPORTS-1:0]            evt_q, evt_d;
  logic [NPORTS-1:0]            evt_set;

  assign in_vec = in_ports;

  // Output port write path.
  always_comb begin
    out_d = out_q;
    stb_d = '0;
    if (wr_en) begin
      stb_d[wr_sel] = 1'b1;
      unique case (op_e'(wr_op))
        OpLoad: out_d[wr_sel] = wr_data;
        OpSet:  out_d[wr_sel] = out_q[wr_sel] | wr_data;
        OpClr:  out_d[wr_sel] = out_q[wr_sel] & ~wr_data;
        OpTgl:  out_d[wr_sel] = out_q[wr_sel] ^ wr_data;
        default: out_d[wr_sel] = out_q[wr_sel];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      stb_q <= '0;
    end else begin
      out_q <= out_d;
      stb_q <= stb_d;
    end
  end

  // Input synchroniser plus history stage used for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= in_vec;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    evt_set = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      evt_set[p] = (s2_q[p] != s3_q[p]);
    end
  end

  // Set is OR-ed in after the acknowledge so a coinciding change keeps the flag.
  always_comb begin
    evt_d = evt_q;
    if (rd_ack) begin
      evt_d[rd_sel] = 1'b0;
    end
    evt_d = evt_d | evt_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign out_ports = out_q;
  assign out_stb   = stb_q;
  assign evt       = evt_q;
  assign rd_data   = s2_q[rd_sel];
  assign irq       = |(evt_q & irq_mask);

endmodule
